cp0_nested_exc: RTL and testbench

Parametrised coprocessor-0 exception/interrupt controller for the 5-stage MIPS core. It sits beside the MEM stage. It decides each cycle whether the pipeline must be flushed and redirected to the handler. It holds SR, Cause, EPC and PRId. Unlike the single-level CP0, it supports a configurable number of hardware interrupt lines and a nested EPC stack, so interrupts can be re-entered while a handler runs.

---
 rtl/cp0_nested_exc.sv | 109 ++++++++++
 tb/tb_cp0_nested_exc.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/cp0_nested_exc.sv
// cp0_nested_exc: CP0 exception/interrupt controller with nested EPC/ExcCode stack
module cp0_nested_exc #(
   parameter int          NUM_HWINT = 6,
   parameter int          EPC_DEPTH = 4,
   parameter logic [31:0] PRID      = 32'h0000_0B0A
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [4:0]                  a_rd,
   input  logic                        we,
   input  logic [31:0]                 din,
   input  logic [31:0]                 pc_m,
   input  logic                        bd,
   input  logic [4:0]                  exc_code_in,
   input  logic [NUM_HWINT-1:0]        hw_int,
   input  logic                        eret,
   output logic                        interrupt,
   output logic [31:0]                 epc,
   output logic [31:0]                 dout,
   output logic [$clog2(EPC_DEPTH):0]  level,
   output logic                        stack_ovf
);
   localparam int IW = $clog2(EPC_DEPTH);
   localparam int LW = IW + 1;
   localparam logic [LW-1:0] FULL = LW'(EPC_DEPTH);
   logic                 ie;
   logic                 ne;
   logic [NUM_HWINT-1:0] im;
   logic [NUM_HWINT-1:0] ip;
   logic                 cause_bd;
   logic [4:0]           exc_code;
   logic [31:0]          stk_epc [EPC_DEPTH];
   logic [4:0]           stk_code [EPC_DEPTH];
   logic [IW-1:0]        top;
   logic [IW-1:0]        wr_idx;
   logic                 hw_take;
   logic                 replace;
   logic                 grow;
   logic [31:0]          new_epc;
   logic [4:0]           pop_code;
   logic [31:0]          sr;
   logic [31:0]          cause;
   // take decision and stack addressing; a simultaneous eret turns a push into an in-place replace
   always_comb begin
      hw_take   = ie & (|(hw_int & im)) & ((level == '0) | ne);
      interrupt = (exc_code_in != 5'd0) | hw_take;
      replace   = eret & (level != '0);
      grow      = ~replace & (level != FULL);
      top       = (level == '0) ? '0 : IW'(level - LW'(1));
      wr_idx    = grow ? IW'(level) : top;
      new_epc   = (bd ? pc_m - 32'd4 : pc_m) & ~32'd3;
      pop_code  = (level == LW'(1)) ? 5'd0 : stk_code[IW'(level - LW'(2))];
      epc       = stk_epc[top];
   end
   // architectural SR/Cause views and the mfc0 read mux
   always_comb begin
      sr                   = '0;
      sr[0]                = ie;
      sr[1]                = level != '0;
      sr[2]                = ne;
      sr[9+NUM_HWINT:10]   = im;
      cause                = '0;
      cause[31]            = cause_bd;
      cause[9+NUM_HWINT:10] = ip;
      cause[6:2]           = exc_code;
      dout = (a_rd == 5'd12) ? sr :
             (a_rd == 5'd13) ? cause :
             (a_rd == 5'd14) ? epc :
             (a_rd == 5'd15) ? PRID : '0;
   end
   // state update: take beats pop and mtc0; mtc0 and eret may both apply
   always_ff @(posedge clk) begin
      if (!reset) begin
         ie        <= 1'b0;
         ne        <= 1'b0;
         im        <= '0;
         ip        <= '0;
         cause_bd  <= 1'b0;
         exc_code  <= 5'd0;
         level     <= '0;
         stack_ovf <= 1'b0;
         for (int i = 0; i < EPC_DEPTH; i++) begin
            stk_epc[i]  <= '0;
            stk_code[i] <= '0;
         end
      end else begin
         ip <= hw_int;
         if (interrupt) begin
            stk_epc[wr_idx]  <= new_epc;
            stk_code[wr_idx] <= exc_code_in;
            cause_bd         <= bd;
            exc_code         <= exc_code_in;
            level            <= level + LW'(grow);
            if (~replace & ~grow) stack_ovf <= 1'b1;
         end else begin
            if (replace) begin
               level    <= level - LW'(1);
               exc_code <= pop_code;
            end
            if (we && a_rd == 5'd12) begin
               ie <= din[0];
               ne <= din[2];
               im <= din[9+NUM_HWINT:10];
            end
            if (we && a_rd == 5'd14) stk_epc[top] <= din & ~32'd3;
         end
      end
   end
endmodule

// File: tb/tb_cp0_nested_exc.sv
// tb_cp0_nested_exc: scoreboard bench for the nested CP0 controller (EPC_DEPTH=2)
module tb_cp0_nested_exc;
   typedef struct {
      logic [31:0] epc;
      logic [1:0]  lvl;
      logic        ovf;
   } exp_t;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [4:0]  a_rd;
   logic        we;
   logic [31:0] din;
   logic [31:0] pc_m;
   logic        bd;
   logic [4:0]  exc_code_in;
   logic [5:0]  hw_int;
   logic        eret;
   logic        interrupt;
   logic [31:0] epc;
   logic [31:0] dout;
   logic [1:0]  level;
   logic        stack_ovf;
   exp_t        q[$];
   exp_t        e;
   int          errors = 0;
   int          checks = 0;
   always #5 clk = ~clk;
   cp0_nested_exc #(.NUM_HWINT(6), .EPC_DEPTH(2), .PRID(32'h0000_0B0A)) dut (
      .clk(clk), .reset(reset), .a_rd(a_rd), .we(we), .din(din), .pc_m(pc_m), .bd(bd),
      .exc_code_in(exc_code_in), .hw_int(hw_int), .eret(eret), .interrupt(interrupt),
      .epc(epc), .dout(dout), .level(level), .stack_ovf(stack_ovf)
   );
   task automatic idle();
      a_rd = 5'd0; we = 1'b0; din = '0; pc_m = '0; bd = 1'b0;
      exc_code_in = 5'd0; hw_int = '0; eret = 1'b0;
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic test_reset();
      idle();
      reset = 1'b0;
      repeat (3) tick();
      reset = 1'b1;
      a_rd = 5'd12; #1;
      checks++; if (dout !== 32'h0) begin errors++; $display("FAIL reset_sr: got %h want %h", dout, 32'h0); end
      a_rd = 5'd13; #1;
      checks++; if (dout !== 32'h0) begin errors++; $display("FAIL reset_cause: got %h want %h", dout, 32'h0); end
      checks++; if ({epc, level, stack_ovf, interrupt} !== {32'h0, 2'd0, 1'b0, 1'b0}) begin
         errors++; $display("FAIL reset_outputs: got epc=%h lvl=%0d ovf=%b int=%b want 0", epc, level, stack_ovf, interrupt);
      end
      a_rd = 5'd15; #1;
      checks++; if (dout !== 32'h0000_0B0A) begin errors++; $display("FAIL prid: got %h want %h", dout, 32'h0000_0B0A); end
      a_rd = 5'd7; #1;
      checks++; if (dout !== 32'h0) begin errors++; $display("FAIL unmapped_read: got %h want %h", dout, 32'h0); end
   endtask
   task automatic test_sync_exc();
      idle();
      exc_code_in = 5'd12; pc_m = 32'h3010; #1;
      checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL sync_int: got %b want 1", interrupt); end
      q.push_back(exp_t'{32'h3010, 2'd1, 1'b0});
      tick(); idle(); #1;
      e = q.pop_front();
      checks++; if ({epc, level, stack_ovf} !== {e.epc, e.lvl, e.ovf}) begin
         errors++; $display("FAIL sync_take: got %h/%0d/%b want %h/%0d/%b", epc, level, stack_ovf, e.epc, e.lvl, e.ovf);
      end
      a_rd = 5'd13; #1;
      checks++; if (dout !== 32'h30) begin errors++; $display("FAIL sync_cause: got %h want %h", dout, 32'h30); end
      a_rd = 5'd12; #1;
      checks++; if (dout !== 32'h2) begin errors++; $display("FAIL sync_exl: got %h want %h", dout, 32'h2); end
      idle(); eret = 1'b1;
      q.push_back(exp_t'{32'h3010, 2'd0, 1'b0});
      tick(); idle(); #1;
      e = q.pop_front();
      checks++; if ({epc, level, stack_ovf} !== {e.epc, e.lvl, e.ovf}) begin
         errors++; $display("FAIL sync_eret: got %h/%0d/%b want %h/%0d/%b", epc, level, stack_ovf, e.epc, e.lvl, e.ovf);
      end
      a_rd = 5'd13; #1;
      checks++; if (dout !== 32'h0) begin errors++; $display("FAIL sync_eret_cause: got %h want %h", dout, 32'h0); end
      idle(); eret = 1'b1;
      q.push_back(exp_t'{32'h3010, 2'd0, 1'b0});
      tick(); idle(); #1;
      e = q.pop_front();
      checks++; if ({epc, level, stack_ovf} !== {e.epc, e.lvl, e.ovf}) begin
         errors++; $display("FAIL eret_level0: got %h/%0d/%b want %h/%0d/%b", epc, level, stack_ovf, e.epc, e.lvl, e.ovf);
      end
   endtask
   task automatic test_delay_slot_int();
      idle();
      a_rd = 5'd12; we = 1'b1; din = 32'h0000_0401;
      tick(); idle(); a_rd = 5'd12; #1;
      checks++; if (dout !== 32'h401) begin errors++; $display("FAIL sr_write: got %h want %h", dout, 32'h401); end
      hw_int = 6'b000001; bd = 1'b1; pc_m = 32'h3008; #1;
      checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL hw_int: got %b want 1", interrupt); end
      q.push_back(exp_t'{32'h3004, 2'd1, 1'b0});
      tick(); bd = 1'b0; pc_m = '0; #1;
      e = q.pop_front();
      checks++; if ({epc, level, stack_ovf} !== {e.epc, e.lvl, e.ovf}) begin
         errors++; $display("FAIL ds_take: got %h/%0d/%b want %h/%0d/%b", epc, level, stack_ovf, e.epc, e.lvl, e.ovf);
      end
      a_rd = 5'd13; #1;
      checks++; if (dout !== 32'h8000_0400) begin errors++; $display("FAIL ds_cause: got %h want %h", dout, 32'h8000_0400); end
   endtask
   task automatic test_nesting();
      #1;
      checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL nest_gate: got %b want 0", interrupt); end
      a_rd = 5'd12; we = 1'b1; din = 32'h0000_0405;
      tick(); we = 1'b0; a_rd = 5'd0; pc_m = 32'h4000; #1;
      checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL nest_open: got %b want 1", interrupt); end
      q.push_back(exp_t'{32'h4000, 2'd2, 1'b0});
      tick(); idle(); #1;
      e = q.pop_front();
      checks++; if ({epc, level, stack_ovf} !== {e.epc, e.lvl, e.ovf}) begin
         errors++; $display("FAIL nest_take: got %h/%0d/%b want %h/%0d/%b", epc, level, stack_ovf, e.epc, e.lvl, e.ovf);
      end
      a_rd = 5'd12; #1;
      checks++; if (dout !== 32'h407) begin errors++; $display("FAIL nest_sr: got %h want %h", dout, 32'h407); end
      idle(); eret = 1'b1;
      q.push_back(exp_t'{32'h3004, 2'd1, 1'b0});
      tick(); idle(); #1;
      e = q.pop_front();
      checks++; if ({epc, level, stack_ovf} !== {e.epc, e.lvl, e.ovf}) begin
         errors++; $display("FAIL nest_eret: got %h/%0d/%b want %h/%0d/%b", epc, level, stack_ovf, e.epc, e.lvl, e.ovf);
      end
      eret = 1'b1;
      q.push_back(exp_t'{32'h3004, 2'd0, 1'b0});
      tick(); idle(); #1;
      e = q.pop_front();
      checks++; if ({epc, level, stack_ovf} !== {e.epc, e.lvl, e.ovf}) begin
         errors++; $display("FAIL nest_eret0: got %h/%0d/%b want %h/%0d/%b", epc, level, stack_ovf, e.epc, e.lvl, e.ovf);
      end
   endtask
   task automatic test_overflow();
      for (int i = 0; i < 3; i++) begin
         idle();
         exc_code_in = 5'(4 + i);
         pc_m = 32'h3000 + 32'(i) * 32'h100;
         q.push_back(exp_t'{pc_m, (i == 0) ? 2'd1 : 2'd2, i == 2});
         tick(); idle(); #1;
         e = q.pop_front();
         checks++; if ({epc, level, stack_ovf} !== {e.epc, e.lvl, e.ovf}) begin
            errors++; $display("FAIL ovf_take%0d: got %h/%0d/%b want %h/%0d/%b", i, epc, level, stack_ovf, e.epc, e.lvl, e.ovf);
         end
      end
      eret = 1'b1;
      q.push_back(exp_t'{32'h3000, 2'd1, 1'b1});
      tick(); idle(); #1;
      e = q.pop_front();
      checks++; if ({epc, level, stack_ovf} !== {e.epc, e.lvl, e.ovf}) begin
         errors++; $display("FAIL ovf_eret: got %h/%0d/%b want %h/%0d/%b", epc, level, stack_ovf, e.epc, e.lvl, e.ovf);
      end
      a_rd = 5'd13; #1;
      checks++; if (dout !== 32'h10) begin errors++; $display("FAIL ovf_code_restore: got %h want %h", dout, 32'h10); end
   endtask
   task automatic test_back_to_back();
      idle();
      eret = 1'b1; exc_code_in = 5'd8; pc_m = 32'h5000;
      we = 1'b1; a_rd = 5'd14; din = 32'hDEAD_BEEC; #1;
      checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL simul_int: got %b want 1", interrupt); end
      q.push_back(exp_t'{32'h5000, 2'd1, 1'b1});
      tick(); idle(); #1;
      e = q.pop_front();
      checks++; if ({epc, level, stack_ovf} !== {e.epc, e.lvl, e.ovf}) begin
         errors++; $display("FAIL simul_take: got %h/%0d/%b want %h/%0d/%b", epc, level, stack_ovf, e.epc, e.lvl, e.ovf);
      end
      a_rd = 5'd13; #1;
      checks++; if (dout !== 32'h20) begin errors++; $display("FAIL simul_cause: got %h want %h", dout, 32'h20); end
      idle(); we = 1'b1; a_rd = 5'd14; din = 32'h0000_1237;
      q.push_back(exp_t'{32'h1234, 2'd1, 1'b1});
      tick(); idle(); #1;
      e = q.pop_front();
      checks++; if ({epc, level, stack_ovf} !== {e.epc, e.lvl, e.ovf}) begin
         errors++; $display("FAIL epc_write: got %h/%0d/%b want %h/%0d/%b", epc, level, stack_ovf, e.epc, e.lvl, e.ovf);
      end
      eret = 1'b1; we = 1'b1; a_rd = 5'd12; din = 32'h1;
      q.push_back(exp_t'{32'h1234, 2'd0, 1'b1});
      tick(); idle(); a_rd = 5'd12; #1;
      e = q.pop_front();
      checks++; if ({epc, level, stack_ovf} !== {e.epc, e.lvl, e.ovf}) begin
         errors++; $display("FAIL eret_mtc0: got %h/%0d/%b want %h/%0d/%b", epc, level, stack_ovf, e.epc, e.lvl, e.ovf);
      end
      checks++; if (dout !== 32'h1) begin errors++; $display("FAIL eret_mtc0_sr: got %h want %h", dout, 32'h1); end
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish in time");
      $fatal(1);
   end
   initial begin
      test_reset();
      test_sync_exc();
      test_delay_slot_int();
      test_nesting();
      test_overflow();
      test_back_to_back();
      checks++; if (q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d left want 0", q.size()); end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
